// File: rtl/booth_datapath_if.sv
// Booth datapath bus: controller commands and operands in, recode pair,
// product and done flag out.
interface booth_datapath_if #(
   parameter int unsigned N = 8
) ();
   logic [N-1:0]   mcand;
   logic [N-1:0]   mplier;
   logic [1:0]     q_mode;
   logic [1:0]     a_mode;
   logic           m_ld;
   logic           alu_sub;
   logic           cnt_en;
   logic           c1;
   logic           c2;
   logic [2*N-1:0] product;
   logic           done;

   // Controller / consumer side
   modport master (
      output mcand, mplier, q_mode, a_mode, m_ld, alu_sub, cnt_en,
      input  c1, c2, product, done
   );

   // Datapath side
   modport slave (
      input  mcand, mplier, q_mode, a_mode, m_ld, alu_sub, cnt_en,
      output c1, c2, product, done
   );
endinterface

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier register datapath: A, Q, Q-1, M, add/sub ALU and
// iteration counter, driven by per-cycle commands from the control FSM.
module booth_datapath #(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = 4
) (
   input  logic            clk,
   input  logic            rst,
   booth_datapath_if.slave bus
);

   typedef enum logic [1:0] {
      CMD_HOLD = 2'b00,
      CMD_LOAD = 2'b01,
      CMD_ASR  = 2'b10,
      CMD_CLR  = 2'b11
   } cmd_e;

   // A carries one guard bit so that A - M cannot overflow for
   // -2^(N-1) x -2^(N-1); only the low N bits are visible in the product.
   logic [N:0]    a_q, a_d;
   logic [N-1:0]  q_q, q_d;
   logic          qm1_q, qm1_d;
   logic [N-1:0]  m_q, m_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N:0]    m_ext;
   logic [N:0]    alu;
   cmd_e          a_cmd;
   cmd_e          q_cmd;

   assign a_cmd = cmd_e'(bus.a_mode);
   assign q_cmd = cmd_e'(bus.q_mode);
   assign m_ext = {m_q[N-1], m_q};

   // ALU on current A and M (old M when m_ld coincides with an A load)
   always_comb begin
      alu = bus.alu_sub ? (a_q - m_ext) : (a_q + m_ext);
   end

   // Next-state for A, Q, Q-1, M and the saturating counter
   always_comb begin
      a_d   = a_q;
      q_d   = q_q;
      qm1_d = qm1_q;
      m_d   = bus.m_ld ? bus.mcand : m_q;
      cnt_d = cnt_q;

      case (a_cmd)
         CMD_LOAD: a_d = alu;
         CMD_ASR:  a_d = {a_q[N], a_q[N:1]};
         CMD_CLR:  a_d = '0;
         default:  a_d = a_q;
      endcase

      if (bus.cnt_en && (cnt_q != CW'(N))) begin
         cnt_d = cnt_q + CW'(1);
      end

      // Q shift takes the pre-edge A[0], so a joint A/Q shift is one
      // arithmetic shift of {A,Q,Q-1}.
      case (q_cmd)
         CMD_LOAD: begin
            q_d   = bus.mplier;
            qm1_d = 1'b0;
            cnt_d = '0;
         end
         CMD_ASR: begin
            q_d   = {a_q[0], q_q[N-1:1]};
            qm1_d = q_q[0];
         end
         CMD_CLR: begin
            q_d   = '0;
            qm1_d = 1'b0;
         end
         default: begin
            q_d   = q_q;
            qm1_d = qm1_q;
         end
      endcase
   end

   // State registers with synchronous reset overriding all commands
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         q_q   <= '0;
         qm1_q <= 1'b0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         q_q   <= q_d;
         qm1_q <= qm1_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.c1      = q_q[0];
   assign bus.c2      = qm1_q;
   assign bus.product = {a_q[N-1:0], q_q};
   assign bus.done    = (cnt_q == CW'(N));

endmodule
